// File: rtl/face_scheduler.sv
// -----------------------------------------------------------------------------
// face_scheduler
//
// Frame-level sequencer for the shader triangle rasterizer. Walks a list of
// 10-word face records in the face RAM and fetches each face's vertices and
// colour. Back-facing (optional) and degenerate faces are culled. Each
// surviving face is presented to the shader with one start/done handshake.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   frame_start   one-cycle pulse, begins a frame (honoured only when idle)
//   base_addr     word address of face 0, sampled on frame_start
//   face_count    number of faces, sampled on frame_start
//   mem_addr      face-RAM read address
//   mem_rdata     face-RAM read data, valid one cycle after mem_addr
//   v1x..v3z      vertex coordinates to the shader
//   pixel_color   face colour to the shader
//   shader_start  one-cycle start pulse to the shader
//   shader_done   shader completion (only sampled while waiting)
//   busy          high from accepted frame_start until frame_done
//   frame_done    one-cycle pulse at frame end
//   timeout_err   sticky shader-timeout flag, cleared by next accepted frame
//   faces_drawn   per-frame count of faces handed to the shader (saturating)
//   faces_culled  per-frame count of culled faces (saturating)
// -----------------------------------------------------------------------------
module face_scheduler #(
    parameter int ADDR_W  = 12,
    parameter int CNT_W   = 10,
    parameter int CULL_EN = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  face_count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       v1x,
    output logic [15:0]       v1y,
    output logic [15:0]       v1z,
    output logic [15:0]       v2x,
    output logic [15:0]       v2y,
    output logic [15:0]       v2z,
    output logic [15:0]       v3x,
    output logic [15:0]       v3y,
    output logic [15:0]       v3z,
    output logic [15:0]       pixel_color,
    output logic              shader_start,
    input  logic              shader_done,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err,
    output logic [15:0]       faces_drawn,
    output logic [15:0]       faces_culled
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CULL  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    // Word slots inside a face record
    localparam int W_X1 = 0;
    localparam int W_Y1 = 1;
    localparam int W_X2 = 3;
    localparam int W_Y2 = 4;
    localparam int W_X3 = 6;
    localparam int W_Y3 = 7;

    logic [2:0]        r_state;
    logic [3:0]        r_word;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_face_addr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_idx;
    logic [TMO_W-1:0]  r_tmo;
    logic [9:0][15:0]  r_hold;
    logic [9:0][15:0]  r_out;
    logic              r_timeout_err;
    logic [15:0]       r_drawn;
    logic [15:0]       r_culled;

    logic signed [16:0] w_dx2;
    logic signed [16:0] w_dy2;
    logic signed [16:0] w_dx3;
    logic signed [16:0] w_dy3;
    logic signed [33:0] w_prod_a;
    logic signed [33:0] w_prod_b;
    logic signed [34:0] w_area;
    logic               w_cull;
    logic [CNT_W-1:0]   w_idx_next;
    logic [ADDR_W-1:0]  w_next_face;

    // Coordinates are treated as unsigned screen positions; the 17-bit
    // differences hold any pair exactly, and the 35-bit result cannot overflow.
    assign w_dx2 = $signed({1'b0, r_hold[W_X2]}) - $signed({1'b0, r_hold[W_X1]});
    assign w_dy2 = $signed({1'b0, r_hold[W_Y2]}) - $signed({1'b0, r_hold[W_Y1]});
    assign w_dx3 = $signed({1'b0, r_hold[W_X3]}) - $signed({1'b0, r_hold[W_X1]});
    assign w_dy3 = $signed({1'b0, r_hold[W_Y3]}) - $signed({1'b0, r_hold[W_Y1]});

    assign w_prod_a = 34'(w_dx2) * 34'(w_dy3);
    assign w_prod_b = 34'(w_dx3) * 34'(w_dy2);
    assign w_area   = 35'(w_prod_a) - 35'(w_prod_b);

    // Zero area is always culled, so with the zero case already covered a
    // clear sign bit is enough to mean "strictly positive".
    assign w_cull = (w_area == '0) || ((CULL_EN != 0) && !w_area[34]);

    assign w_idx_next  = r_idx + 1'b1;
    assign w_next_face = r_face_addr + ADDR_W'(10);

    // Control FSM, address generation, statistics and shader output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_word        <= '0;
            r_mem_addr    <= '0;
            r_face_addr   <= '0;
            r_count       <= '0;
            r_idx         <= '0;
            r_tmo         <= '0;
            r_out         <= '0;
            r_timeout_err <= 1'b0;
            r_drawn       <= '0;
            r_culled      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_count       <= face_count;
                        r_idx         <= '0;
                        r_face_addr   <= base_addr;
                        r_word        <= '0;
                        r_drawn       <= '0;
                        r_culled      <= '0;
                        r_timeout_err <= 1'b0;
                        if (face_count == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_mem_addr <= base_addr;
                            r_state    <= S_FETCH;
                        end
                    end
                end

                // r_word counts fetch cycles 0..10: addresses go out on 0..9,
                // the matching data word lands one cycle later on 1..10.
                S_FETCH: begin
                    if (r_word < 4'd9) begin
                        r_mem_addr <= r_mem_addr + 1'b1;
                    end
                    if (r_word == 4'd10) begin
                        r_state <= S_CULL;
                    end else begin
                        r_word <= r_word + 1'b1;
                    end
                end

                S_CULL: begin
                    if (w_cull) begin
                        if (r_culled != 16'hFFFF) begin
                            r_culled <= r_culled + 1'b1;
                        end
                        r_state <= S_NEXT;
                    end else begin
                        r_out   <= r_hold;
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (shader_done) begin
                        if (r_drawn != 16'hFFFF) begin
                            r_drawn <= r_drawn + 1'b1;
                        end
                        r_state <= S_NEXT;
                    end else if (r_tmo == TMO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_FIN;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_NEXT: begin
                    r_idx <= w_idx_next;
                    if (w_idx_next == r_count) begin
                        r_state <= S_FIN;
                    end else begin
                        r_face_addr <= w_next_face;
                        r_mem_addr  <= w_next_face;
                        r_word      <= '0;
                        r_state     <= S_FETCH;
                    end
                end

                S_FIN: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Holding registers: pure data, captured one cycle after each address
    always_ff @(posedge clk) begin
        if (r_state == S_FETCH) begin
            for (int k = 0; k < 10; k++) begin
                if (r_word == 4'(k + 1)) begin
                    r_hold[k] <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr     = r_mem_addr;
    assign v1x          = r_out[0];
    assign v1y          = r_out[1];
    assign v1z          = r_out[2];
    assign v2x          = r_out[3];
    assign v2y          = r_out[4];
    assign v2z          = r_out[5];
    assign v3x          = r_out[6];
    assign v3y          = r_out[7];
    assign v3z          = r_out[8];
    assign pixel_color  = r_out[9];
    assign shader_start = (r_state == S_ISSUE);
    assign frame_done   = (r_state == S_FIN);
    // busy drops in the FIN cycle so it falls together with frame_done
    assign busy         = (r_state != S_IDLE) && (r_state != S_FIN);
    assign timeout_err  = r_timeout_err;
    assign faces_drawn  = r_drawn;
    assign faces_culled = r_culled;

endmodule

// File: tb/tb_face_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_face_scheduler
//
// Directed and randomized bench for face_scheduler. Instance A uses back-face
// culling, instance B draws every non-degenerate face. A behavioural model
// computes the expected drawn faces, culled count and address stream
// directly from the face records stored in the bench memory.
// -----------------------------------------------------------------------------
module tb_face_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        fs_a;
    logic        fs_b;
    logic [11:0] base_addr;
    logic [9:0]  face_count;
    logic [15:0] mem [0:4095];

    // instance A (culling enabled)
    wire  [11:0] a_addr;
    logic [15:0] a_rdata;
    wire  [15:0] a_v1x, a_v1y, a_v1z, a_v2x, a_v2y, a_v2z, a_v3x, a_v3y, a_v3z, a_col;
    wire         a_start, a_busy, a_frame_done, a_terr;
    wire  [15:0] a_drawn, a_culled;
    logic        a_done_auto;
    logic        done_man;
    wire         a_done = a_done_auto | done_man;
    wire [159:0] a_rec = {a_v1x, a_v1y, a_v1z, a_v2x, a_v2y, a_v2z, a_v3x, a_v3y, a_v3z, a_col};

    // instance B (culling disabled)
    wire  [11:0] b_addr;
    logic [15:0] b_rdata;
    wire  [15:0] b_v1x, b_v1y, b_v1z, b_v2x, b_v2y, b_v2z, b_v3x, b_v3y, b_v3z, b_col;
    wire         b_start, b_busy, b_frame_done, b_terr;
    wire  [15:0] b_drawn, b_culled;
    logic        b_done;

    face_scheduler #(.ADDR_W(12), .CNT_W(10), .CULL_EN(1), .TIMEOUT(4096)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .frame_start(fs_a), .base_addr(base_addr),
        .face_count(face_count), .mem_addr(a_addr), .mem_rdata(a_rdata),
        .v1x(a_v1x), .v1y(a_v1y), .v1z(a_v1z), .v2x(a_v2x), .v2y(a_v2y), .v2z(a_v2z),
        .v3x(a_v3x), .v3y(a_v3y), .v3z(a_v3z), .pixel_color(a_col),
        .shader_start(a_start), .shader_done(a_done), .busy(a_busy),
        .frame_done(a_frame_done), .timeout_err(a_terr),
        .faces_drawn(a_drawn), .faces_culled(a_culled)
    );

    face_scheduler #(.ADDR_W(12), .CNT_W(10), .CULL_EN(0), .TIMEOUT(4096)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .frame_start(fs_b), .base_addr(base_addr),
        .face_count(face_count), .mem_addr(b_addr), .mem_rdata(b_rdata),
        .v1x(b_v1x), .v1y(b_v1y), .v1z(b_v1z), .v2x(b_v2x), .v2y(b_v2y), .v2z(b_v2z),
        .v3x(b_v3x), .v3y(b_v3y), .v3z(b_v3z), .pixel_color(b_col),
        .shader_start(b_start), .shader_done(b_done), .busy(b_busy),
        .frame_done(b_frame_done), .timeout_err(b_terr),
        .faces_drawn(b_drawn), .faces_culled(b_culled)
    );

    // face RAM: one-cycle read latency
    always @(posedge clk) begin
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
    end

    // shader models: answer done a programmable number of cycles after start
    logic auto_a;
    int   dly_a;
    int   cnt_a;
    int   cnt_b;
    always @(posedge clk) begin
        if (!reset_n || !auto_a) begin
            cnt_a       <= 0;
            a_done_auto <= 1'b0;
        end else begin
            a_done_auto <= 1'b0;
            if (a_start) cnt_a <= dly_a;
            else if (cnt_a == 1) begin a_done_auto <= 1'b1; cnt_a <= 0; end
            else if (cnt_a > 1) cnt_a <= cnt_a - 1;
        end
    end
    always @(posedge clk) begin
        if (!reset_n) begin
            cnt_b  <= 0;
            b_done <= 1'b0;
        end else begin
            b_done <= 1'b0;
            if (b_start) cnt_b <= 2;
            else if (cnt_b == 1) begin b_done <= 1'b1; cnt_b <= 0; end
            else if (cnt_b > 1) cnt_b <= cnt_b - 1;
        end
    end

    // monitors: address stream, presented faces, output stability
    logic [11:0]  addr_q[$];
    logic [159:0] start_q[$];
    int           stab_err = 0;
    int           b_starts = 0;
    always @(negedge clk) begin
        if (reset_n && a_busy) begin
            if (addr_q.size() == 0 || addr_q[$] != a_addr) addr_q.push_back(a_addr);
            if (a_start) start_q.push_back(a_rec);
            else if (start_q.size() > 0 && a_rec != start_q[$]) stab_err <= stab_err + 1;
        end
        if (reset_n && b_start) b_starts <= b_starts + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_face(input logic [11:0] fa, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4,
                              input logic [15:0] w5, input logic [15:0] w6, input logic [15:0] w7,
                              input logic [15:0] w8, input logic [15:0] w9);
        logic [15:0] w [10];
        w = '{w0, w1, w2, w3, w4, w5, w6, w7, w8, w9};
        for (int k = 0; k < 10; k++) mem[12'(fa + k)] = w[k];
    endtask

    // signed doubled triangle area straight from the record in memory
    function automatic longint area_at(input logic [11:0] fa);
        longint x1, y1, x2, y2, x3, y3;
        x1 = longint'(mem[fa]);
        y1 = longint'(mem[12'(fa + 1)]);
        x2 = longint'(mem[12'(fa + 3)]);
        y2 = longint'(mem[12'(fa + 4)]);
        x3 = longint'(mem[12'(fa + 6)]);
        y3 = longint'(mem[12'(fa + 7)]);
        return (x2 - x1) * (y3 - y1) - (x3 - x1) * (y2 - y1);
    endfunction

    function automatic logic [159:0] rec_at(input logic [11:0] fa);
        logic [159:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r = {r[143:0], mem[12'(fa + k)]};
        return r;
    endfunction

    // kind 0: degenerate, 1: guaranteed front-facing (drawn by A), 2: random
    task automatic gen_face(input logic [11:0] fa, input int kind);
        logic [15:0] w [10];
        longint ar;
        for (int tries = 0; tries < 100; tries++) begin
            for (int k = 0; k < 10; k++) w[k] = 16'($urandom);
            for (int k = 0; k < 9; k++) if (k != 2 && k != 5 && k != 8) w[k] = w[k] & 16'h7FFF;
            if (kind == 0) begin
                w[3] = w[0]; w[4] = w[1]; w[6] = w[0]; w[7] = w[1];
            end
            write_face(fa, w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8], w[9]);
            ar = area_at(fa);
            if (kind != 1 || ar < 0) break;
            if (ar > 0) begin
                write_face(fa, w[0], w[1], w[2], w[6], w[7], w[8], w[3], w[4], w[5], w[9]);
                break;
            end
        end
    endtask

    task automatic run_random_frame(input logic [11:0] b, input int n, input int kind_mode);
        logic [159:0] exp_q[$];
        int           exp_culled;
        int           nwait;
        int           s0;
        logic [11:0]  fa;
        exp_culled = 0;
        for (int i = 0; i < n; i++) begin
            fa = 12'(b + 10 * i);
            gen_face(fa, (kind_mode >= 0) ? kind_mode : (($urandom_range(0, 4) == 0) ? 0 : 2));
        end
        for (int i = 0; i < n; i++) begin
            fa = 12'(b + 10 * i);
            if (area_at(fa) >= 0) exp_culled++;
            else exp_q.push_back(rec_at(fa));
        end
        start_q.delete();
        addr_q.delete();
        s0 = stab_err;
        auto_a = 1'b1;
        dly_a = $urandom_range(1, 6);
        base_addr = b; face_count = 10'(n); fs_a = 1'b1;
        step(); fs_a = 1'b0; nwait = 1;
        while (!a_frame_done && nwait < 3000) begin step(); nwait++; end
        check("rnd_frame_done", a_frame_done, 1'b1);
        check("rnd_starts", start_q.size(), exp_q.size());
        for (int k = 0; k < start_q.size() && k < exp_q.size(); k++) check("rnd_face", start_q[k], exp_q[k]);
        check("rnd_naddr", addr_q.size(), 10 * n);
        for (int j = 0; j < addr_q.size() && j < 10 * n; j++) check("rnd_addr", addr_q[j], 12'(b + j));
        check("rnd_drawn", a_drawn, 16'(exp_q.size()));
        check("rnd_culled", a_culled, 16'(exp_culled));
        check("rnd_terr", a_terr, 1'b0);
        check("rnd_stable", stab_err - s0, 0);
        step();
    endtask

    int          n;
    int          s0;
    int          fd_seen;
    logic [11:0] saved_addr;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        reset_n = 1'b0; fs_a = 1'b0; fs_b = 1'b0; base_addr = '0; face_count = '0;
        done_man = 1'b0; auto_a = 1'b0; dly_a = 1;
        #1;
        check("rst_busy", a_busy, 1'b0);
        check("rst_addr", a_addr, 12'h000);
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("reset_outputs", {a_rec, a_addr, a_start, a_busy, a_frame_done, a_terr}, '0);
        check("reset_stats", {a_drawn, a_culled}, 32'h0);

        // single drawn face, cycle-exact
        write_face(12'h100, 16'h27fc, 16'h1b5f, 16'h0178, 16'h315f, 16'h1b57, 16'h0178,
                   16'h30a9, 16'h1ab2, 16'h017b, 16'h0001);
        base_addr = 12'h100; face_count = 10'd1; fs_a = 1'b1;       // cycle 0
        check("t1_idle_busy", a_busy, 1'b0);
        step(); fs_a = 1'b0;                                        // cycle 1
        check("t1_busy", a_busy, 1'b1);
        check("t1_addr0", a_addr, 12'h100);
        repeat (4) step();                                          // cycle 5
        check("t1_addr4", a_addr, 12'h104);
        repeat (7) step();                                          // cycle 12
        check("t1_cull_nostart", a_start, 1'b0);
        step();                                                     // cycle 13
        check("t1_start", a_start, 1'b1);
        check("t1_outputs", a_rec, {16'h27fc, 16'h1b5f, 16'h0178, 16'h315f, 16'h1b57,
                                    16'h0178, 16'h30a9, 16'h1ab2, 16'h017b, 16'h0001});
        done_man = 1'b1;                                            // ignored in ISSUE
        step(); done_man = 1'b0;                                    // cycle 14
        check("t1_start_once", a_start, 1'b0);
        step();                                                     // cycle 15
        check("t1_done_in_issue_ignored", {a_busy, a_drawn}, {1'b1, 16'd0});
        done_man = 1'b1;
        step(); done_man = 1'b0;                                    // cycle 16 (NEXT)
        check("t1_drawn", a_drawn, 16'd1);
        check("t1_no_fd_yet", a_frame_done, 1'b0);
        step();                                                     // cycle 17 (FIN)
        check("t1_frame_done", {a_frame_done, a_busy}, 2'b10);
        step();
        check("t1_fd_pulse", a_frame_done, 1'b0);
        check("t1_culled", a_culled, 16'd0);

        // v2/v3 swapped: culled by A, drawn by B
        write_face(12'h200, 16'h27fc, 16'h1b5f, 16'h0178, 16'h30a9, 16'h1ab2, 16'h017b,
                   16'h315f, 16'h1b57, 16'h0178, 16'h0001);
        start_q.delete(); s0 = b_starts;
        base_addr = 12'h200; face_count = 10'd1; fs_a = 1'b1; fs_b = 1'b1;
        step(); fs_a = 1'b0; fs_b = 1'b0; n = 1;
        while (!a_frame_done && n < 100) begin step(); n++; end
        check("t2_fd_cycle", n, 14);
        check("t2_culled", {a_culled, a_drawn}, {16'd1, 16'd0});
        check("t2_no_start", start_q.size(), 0);
        n = 0;
        while (!b_frame_done && n < 100) begin step(); n++; end
        check("t2b_drawn", {b_frame_done, b_drawn, b_culled}, {1'b1, 16'd1, 16'd0});
        check("t2b_starts", b_starts - s0, 1);
        check("t2b_v2x", b_v2x, 16'h30a9);
        step();

        // degenerate: culled by both
        write_face(12'h300, 16'h0100, 16'h0100, 16'h0005, 16'h0100, 16'h0100, 16'h0006,
                   16'h0100, 16'h0100, 16'h0007, 16'h00ff);
        s0 = b_starts;
        base_addr = 12'h300; face_count = 10'd1; fs_a = 1'b1; fs_b = 1'b1;
        step(); fs_a = 1'b0; fs_b = 1'b0; n = 1;
        while (!a_frame_done && n < 100) begin step(); n++; end
        check("t3_fd_cycle", n, 14);
        check("t3_a_culled", a_culled, 16'd1);
        check("t3_b_culled", {b_frame_done, b_culled, b_drawn}, {1'b1, 16'd1, 16'd0});
        check("t3_b_nostart", b_starts - s0, 0);
        step();

        // address wrap, three drawn faces
        run_random_frame(12'hFFA, 3, 1);

        // shader timeout
        auto_a = 1'b0; done_man = 1'b0;
        base_addr = 12'h100; face_count = 10'd1; fs_a = 1'b1;
        step(); fs_a = 1'b0; n = 1;
        while (!a_frame_done && n < 5000) begin step(); n++; end
        check("t5_fd_cycle", n, 4110);
        check("t5_terr", {a_terr, a_busy, a_drawn}, {1'b1, 1'b0, 16'd0});
        step();
        check("t5_terr_sticky", a_terr, 1'b1);
        auto_a = 1'b1; dly_a = 2;
        fs_a = 1'b1;
        step(); fs_a = 1'b0; n = 1;
        check("t5_terr_cleared", a_terr, 1'b0);
        while (!a_frame_done && n < 100) begin step(); n++; end
        check("t5_second_frame", {a_frame_done, a_terr, a_drawn}, {1'b1, 1'b0, 16'd1});
        step();

        // face_count == 0
        saved_addr = a_addr;
        base_addr = 12'h555; face_count = 10'd0; fs_a = 1'b1;
        step(); fs_a = 1'b0;
        check("t6_zero_fd", {a_frame_done, a_busy}, 2'b10);
        check("t6_zero_noread", a_addr, saved_addr);
        step();
        check("t6_zero_pulse", a_frame_done, 1'b0);

        // frame_start while busy is ignored
        start_q.delete(); addr_q.delete();
        auto_a = 1'b1; dly_a = 3;
        base_addr = 12'h100; face_count = 10'd1; fs_a = 1'b1;
        step(); fs_a = 1'b0;
        repeat (4) step();
        base_addr = 12'h300; face_count = 10'd2; fs_a = 1'b1;
        step(); fs_a = 1'b0; n = 6;
        while (!a_frame_done && n < 100) begin step(); n++; end
        check("t6_busy_ignored", {a_frame_done, a_drawn, a_culled}, {1'b1, 16'd1, 16'd0});
        check("t6_busy_naddr", addr_q.size(), 10);
        check("t6_busy_starts", start_q.size(), 1);
        step();

        // reset during WAIT
        auto_a = 1'b0;
        base_addr = 12'h100; face_count = 10'd1; fs_a = 1'b1;
        step(); fs_a = 1'b0;
        repeat (19) step();                                         // cycle 20
        check("t6_in_wait", {a_busy, a_v1x}, {1'b1, 16'h27fc});
        reset_n = 1'b0;
        #1;
        check("t6_rst_outputs", {a_rec, a_addr, a_start, a_busy, a_frame_done, a_terr}, '0);
        check("t6_rst_stats", {a_drawn, a_culled}, 32'h0);
        fd_seen = 0;
        for (int i = 0; i < 3; i++) begin step(); if (a_frame_done) fd_seen++; end
        reset_n = 1'b1;
        step();
        if (a_frame_done) fd_seen++;
        check("t6_rst_no_fd", fd_seen, 0);
        check("t6_rst_idle", a_busy, 1'b0);

        // randomized frames against the model
        for (int f = 0; f < 5; f++) begin
            run_random_frame(12'($urandom), $urandom_range(1, 6), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
